// File: rtl/bin_gray_counter_pkg.sv
// +------------------------------------------------------------------+
// | bin_gray_counter_pkg: shared width default and bin-to-Gray helper  |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

package bin_gray_counter_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int WIDTH_MAX = 16;

  // Operates on the widest legal code; callers zero-extend and truncate.
  function automatic logic [WIDTH_MAX-1:0] bin2gray(input logic [WIDTH_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin_gray_counter_if.sv
// +------------------------------------------------------------------+
// | bin_gray_counter_if: control and count bus of the Gray counter     |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

interface bin_gray_counter_if
  import bin_gray_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] g;
  logic             wrap;

  modport master (
    output en, up, load, load_bin,
    input  bin, g, wrap
  );

  modport slave (
    input  en, up, load, load_bin,
    output bin, g, wrap
  );

endinterface

`default_nettype wire

// File: rtl/bin_gray_counter_bin_gray.sv
// +------------------------------------------------------------------+
// | bin_gray: combinational binary-to-Gray converter                   |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module bin_gray
  import bin_gray_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  wire logic [WIDTH-1:0] b,
  output logic      [WIDTH-1:0] g
);

  assign g = WIDTH'(bin2gray(WIDTH_MAX'(b)));

endmodule

`default_nettype wire

// File: rtl/bin_gray_counter.sv
// +------------------------------------------------------------------+
// | bin_gray_counter: up/down loadable counter with registered Gray    |
// | code and wrap pulse. Rev 1.0                                       |
// +------------------------------------------------------------------+
`default_nettype none

module bin_gray_counter
  import bin_gray_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  bin_gray_counter_if.slave  bus
);

  logic [WIDTH-1:0] cnt_bin;
  logic [WIDTH-1:0] cnt_gray;
  logic             cnt_wrap;

  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             wrap_nxt;

  // Load wins over counting and never reports a wrap, whatever the loaded value.
  always_comb begin
    bin_nxt  = cnt_bin;
    wrap_nxt = 1'b0;
    if (bus.load) begin
      bin_nxt = bus.load_bin;
    end else if (bus.en) begin
      if (bus.up) begin
        bin_nxt  = cnt_bin + WIDTH'(1);
        wrap_nxt = &cnt_bin;
      end else begin
        bin_nxt  = cnt_bin - WIDTH'(1);
        wrap_nxt = ~|cnt_bin;
      end
    end
  end

  // Gray is derived from the next binary value so both land on the same edge.
  bin_gray #(
    .WIDTH (WIDTH)
  ) u_bin_gray (
    .b (bin_nxt),
    .g (gray_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_bin  <= '0;
      cnt_gray <= '0;
      cnt_wrap <= 1'b0;
    end else begin
      cnt_bin  <= bin_nxt;
      cnt_gray <= gray_nxt;
      cnt_wrap <= wrap_nxt;
    end
  end

  assign bus.bin  = cnt_bin;
  assign bus.g    = cnt_gray;
  assign bus.wrap = cnt_wrap;

endmodule

`default_nettype wire

// File: tb/tb_bin_gray_counter.sv
// Directed and randomized checks of bin_gray_counter at WIDTH=4.
`default_nettype none

module tb_bin_gray_counter;
  import bin_gray_counter_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  bin_gray_counter_if #(.WIDTH(W)) bus ();

  bin_gray_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic l, input logic [W-1:0] lb, input logic e, input logic u);
    bus.load = l; bus.load_bin = lb; bus.en = e; bus.up = u;
  endtask

  task automatic check(input string name, input logic [W-1:0] eb, input logic [W-1:0] eg,
                       input logic ew);
    total++;
    if (bus.bin !== eb || bus.g !== eg || bus.wrap !== ew) begin
      bad++;
      $display("FAIL %s: got bin=%h g=%h wrap=%b want bin=%h g=%h wrap=%b",
               name, bus.bin, bus.g, bus.wrap, eb, eg, ew);
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 4'h9, 1'b1, 1'b1);
    rst_n = 1'b0;
    repeat (3) step();
    check("reset_hold", 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_count_up();
    logic [W-1:0] gseq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    drive(1'b0, 4'h0, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    check("count_up_0", 4'h0, gseq[0], 1'b0);
    for (int i = 1; i < 16; i++) begin
      step();
      check($sformatf("count_up_%0d", i), W'(i), gseq[i], 1'b0);
    end
  endtask

  task automatic test_wrap_up();
    step();
    check("wrap_up", 4'h0, 4'h0, 1'b1);
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    step();
    check("wrap_up_clear_hold", 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_load();
    drive(1'b1, 4'hA, 1'b1, 1'b1);
    step();
    check("load_A", 4'hA, 4'hF, 1'b0);
    drive(1'b1, 4'hF, 1'b1, 1'b1);
    step();
    check("load_F_boundary", 4'hF, 4'h8, 1'b0);
    step();
    check("load_F_again_no_wrap", 4'hF, 4'h8, 1'b0);
  endtask

  task automatic test_wrap_down();
    drive(1'b1, 4'h0, 1'b1, 1'b0);
    step();
    check("load_0", 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    step();
    check("wrap_down", 4'hF, 4'h8, 1'b1);
    step();
    check("down_after_wrap", 4'hE, 4'h9, 1'b0);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 4'h7, 1'b0, 1'b1);
    step();
    check("load_7", 4'h7, 4'h4, 1'b0);
    drive(1'b0, 4'h0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", 4'h0, 4'h0, 1'b0);
    drive(1'b1, 4'h5, 1'b1, 1'b1);
    step();
    step();
    check("async_reset_held", 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("first_edge_after_reset", 4'h5, 4'h7, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] eb = bus.bin;
    logic         ew;
    logic [W-1:0] pg;
    logic         was_count;
    for (int i = 0; i < 1000; i++) begin
      drive(($urandom_range(0, 7) == 0), W'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      was_count = !bus.load && bus.en;
      pg = bus.g;
      ew = 1'b0;
      if (bus.load) begin
        eb = bus.load_bin;
      end else if (bus.en) begin
        if (bus.up) begin ew = (eb == 4'hF); eb = eb + 4'h1; end
        else        begin ew = (eb == 4'h0); eb = eb - 4'h1; end
      end
      step();
      check($sformatf("random_%0d", i), eb, W'(bin2gray(16'(eb))), ew);
      total++;
      if (bus.g !== W'(bin2gray(16'(bus.bin)))) begin
        bad++;
        $display("FAIL random_gray_%0d: got g=%h want g=%h", i, bus.g,
                 W'(bin2gray(16'(bus.bin))));
      end
      if (was_count) begin
        total++;
        if ($countones(bus.g ^ pg) != 1) begin
          bad++;
          $display("FAIL random_onebit_%0d: got %0d changed bits want 1",
                   i, $countones(bus.g ^ pg));
        end
      end
    end
  endtask

  initial begin
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    test_reset();
    test_count_up();
    test_wrap_up();
    test_load();
    test_wrap_down();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
